// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses,
// system instruction encodings, cause codes, FSM states and mstatus helpers.
package clint_pkg;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL     = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [31:0] CAUSE_TIMER_DEF = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT_DEF   = 32'h8000_000B;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_W_MEPC     = 3'd1,
    S_W_MCAUSE   = 3'd2,
    S_W_MSTATUS  = 3'd3,
    S_ASSERT     = 3'd4,
    S_W_MRET     = 3'd5,
    S_ASSERT_RET = 3'd6
  } state_e;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[7] = s[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r    = s;
    r[3] = s[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt controller: detects ecall/ebreak/mret and pending
// interrupts, sequences the trap CSR writes and issues a one-cycle redirect.
//
// state        | meaning
// S_IDLE       | waiting for a trigger
// S_W_MEPC     | writing mepc with the saved epc
// S_W_MCAUSE   | writing mcause with the saved cause
// S_W_MSTATUS  | writing mstatus with MIE cleared, MPIE saved
// S_ASSERT     | redirect to mtvec
// S_W_MRET     | writing mstatus with MIE restored
// S_ASSERT_RET | redirect to mepc
module clint
  import clint_pkg::*;
#(
  parameter int          INT_W       = 8,
  parameter logic [31:0] CAUSE_TIMER = CAUSE_TIMER_DEF,
  parameter logic [31:0] CAUSE_EXT   = CAUSE_EXT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             global_int_en_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             hold_flag_o,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      raddr_o,
  output logic [31:0]      data_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        assert_q, assert_d;
  logic [31:0] addr_q, addr_d;

  logic is_idle, sync_trig, mret_trig, async_trig, trig;

  assign is_idle    = (state_q == S_IDLE);
  assign sync_trig  = is_idle && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
  assign mret_trig  = is_idle && (inst_i == INST_MRET);
  assign async_trig = is_idle && (|int_flag_i) && global_int_en_i && !hold_flag_i;
  assign trig       = sync_trig || mret_trig || async_trig;

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync_trig) begin
          state_d = S_W_MEPC;
          epc_d   = inst_addr_i;
          cause_d = (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
        end else if (mret_trig) begin
          state_d = S_W_MRET;
        end else if (async_trig) begin
          state_d = S_W_MEPC;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
        end
      end
      S_W_MEPC:     state_d = S_W_MCAUSE;
      S_W_MCAUSE:   state_d = S_W_MSTATUS;
      S_W_MSTATUS:  state_d = S_ASSERT;
      S_W_MRET:     state_d = S_ASSERT_RET;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    we_d     = 1'b0;
    waddr_d  = '0;
    data_d   = '0;
    assert_d = 1'b0;
    addr_d   = '0;
    unique case (state_d)
      S_W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      S_W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_d;
      end
      S_W_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = trap_mstatus(csr_mstatus_i);
      end
      S_ASSERT: begin
        assert_d = 1'b1;
        addr_d   = csr_mtvec_i;
      end
      S_W_MRET: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mret_mstatus(csr_mstatus_i);
      end
      S_ASSERT_RET: begin
        assert_d = 1'b1;
        addr_d   = csr_mepc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      data_q   <= '0;
      assert_q <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      data_q   <= data_d;
      assert_q <= assert_d;
      addr_q   <= addr_d;
    end
  end

  // Hold must cover the trigger cycle so EX cannot race our CSR writes.
  assign hold_flag_o  = !is_idle || trig;
  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign raddr_o      = '0;
  assign data_o       = data_q;
  assign int_assert_o = assert_q;
  assign int_addr_o   = addr_q;

endmodule
